bitcell_array_ctrl: RTL and testbench
=====================================

BITCELL_ARRAY_CTRL -- requirements
Module: bitcell_array_ctrl

Interface
REQ-001 SHALL have parameter WORDS, default 8, number of bitcell rows (word lines), >=2.
REQ-002 SHALL have parameter WIDTH, default 4, bits per word (bitcell columns).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-004 SHALL have ports: req_valid input 1 request offered; req_ready output 1 request accepted when high with req_valid; req_we input 1 1=write 0=read; req_addr input clog2(WORDS) word index; req_wdata input WIDTH write data.
REQ-005 SHALL have ports: rsp_valid output 1 response pending; rsp_ready input 1 consumer accepts response; rsp_rdata output WIDTH read data (0 for writes); rsp_err output 1 error flag.
REQ-006 SHALL have array-side ports: arr_sel output WORDS one-hot row select; arr_rw output 1 shared read/write (1=write); arr_in output WIDTH shared column write data; arr_out input WIDTH shared tristate column read bus.

Function
REQ-007 SHALL implement FSM states IDLE, SETUP, WRITE, HOLD, READ, CAPTURE, RESP.
REQ-008 IDLE: req_ready=1; on req_valid&req_ready latch we/addr/wdata and go SETUP; otherwise stay.
REQ-009 SETUP (1 cycle): arr_in=latched wdata, arr_sel=0, arr_rw=0; next WRITE if we else READ.
REQ-010 WRITE (1 cycle): arr_sel=onehot(addr), arr_rw=1, arr_in held; next HOLD.
REQ-011 HOLD (1 cycle): arr_sel=0, arr_rw=0, arr_in still held; next RESP with rsp_rdata=0.
REQ-012 READ (1 cycle): arr_sel=onehot(addr), arr_rw=0; next CAPTURE.
REQ-013 CAPTURE (1 cycle): arr_sel still onehot(addr), arr_rw=0; register arr_out into rsp_rdata at end of cycle; next RESP.
REQ-014 RESP: rsp_valid=1, rsp_rdata/rsp_err stable; on rsp_ready go IDLE; backpressure holds RESP indefinitely.
REQ-015 arr_rw SHALL never be 1 in any cycle where arr_sel is 0, and arr_sel SHALL have at most one bit set in every cycle.
REQ-016 Latency: write request accepted at cycle N -> rsp_valid at N+4; read accepted at N -> rsp_valid at N+4.
REQ-017 req_ready SHALL be 0 in every state except IDLE; no request overlap, no bypass from RESP to SETUP.
REQ-018 req_addr >= WORDS SHALL be accepted, produce no arr_sel/arr_rw activity (SETUP->RESP directly), and respond with rsp_err=1, rsp_rdata=0.
REQ-019 An arr_out bit sampled as X/Z in CAPTURE is not corrected; rsp_rdata reflects the sampled value.

Reset
REQ-020 On rst_n low, immediately: state=IDLE, arr_sel=0, arr_rw=0, arr_in=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 while rst_n low, 1 from first clk edge after release.
REQ-021 Reset mid-operation (any state) SHALL abort the access; no partial write pulse shall follow deassertion.

Configuration
REQ-022 Macro BITCELL_ARRAY_CTRL_PARITY_EN: when defined, arr_in/arr_out widen to WIDTH+1, bit WIDTH carries even parity of wdata on write; on read, parity mismatch sets rsp_err=1 (rsp_rdata still returned).
REQ-023 Without BITCELL_ARRAY_CTRL_PARITY_EN: arr_in/arr_out are WIDTH bits and rsp_err reflects only REQ-018.

Structure
REQ-024 Package bitcell_array_pkg SHALL hold the FSM state enum, the state encoding constants and the parity helper function.
REQ-025 Sub-module bitcell_row_decoder SHALL perform addr -> one-hot arr_sel with enable and out-of-range detect; instantiated once.

Verification
REQ-026 Write addr=3 data=4'b1010 then read addr=3 -> rsp_rdata=4'b1010, rsp_err=0, each rsp_valid 4 cycles after acceptance.
REQ-027 Write addr=0 data=4'hF, write addr=7 data=4'h0, read both -> 4'hF and 4'h0; no cross-row disturbance.
REQ-028 Read with rsp_ready held low 10 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout, single acceptance after.
REQ-029 req_addr=9 with WORDS=8 -> arr_sel stays 0, arr_rw stays 0, rsp_err=1, rsp_rdata=0.
REQ-030 rst_n pulsed low during WRITE -> arr_sel=0, arr_rw=0 immediately, state IDLE, prior row contents of other rows unchanged.
REQ-031 With PARITY_EN, force arr_out parity bit inverted during read -> rsp_err=1, rsp_rdata=stored data.

Source files
------------

// File: rtl/bitcell_array_pkg.sv
// rtl/bitcell_array_pkg.sv - FSM states, state encodings and parity helper (BITCELL_ARRAY_CTRL_PARITY_EN)
package bitcell_array_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_READ    = 3'd4;
    localparam logic [2:0] ST_CAPTURE = 3'd5;
    localparam logic [2:0] ST_RESP    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_SETUP   = ST_SETUP,
        S_WRITE   = ST_WRITE,
        S_HOLD    = ST_HOLD,
        S_READ    = ST_READ,
        S_CAPTURE = ST_CAPTURE,
        S_RESP    = ST_RESP
    } state_e;

    // Number of extra check columns stored alongside each word.
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Even parity bit: makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/bitcell_row_decoder.sv
// rtl/bitcell_row_decoder.sv - word index to one-hot row select with enable and out-of-range detect
module bitcell_row_decoder #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [WORDS-1:0]  sel_o,
    output logic              oob_o
);

    // An out-of-range index never selects a row, even when enabled.
    always_comb begin
        oob_o = (32'(addr_i) >= 32'(WORDS));
        sel_o = '0;
        for (int i = 0; i < WORDS; i++) begin
            sel_o[i] = en_i && !oob_o && (32'(addr_i) == 32'(i));
        end
    end

endmodule

// File: rtl/bitcell_array_ctrl.sv
// rtl/bitcell_array_ctrl.sv - sequenced single-port bitcell array access controller (BITCELL_ARRAY_CTRL_PARITY_EN)
module bitcell_array_ctrl
    import bitcell_array_pkg::*;
#(
    parameter int WORDS  = 8,
    parameter int WIDTH  = 4,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [WIDTH-1:0]          req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_rdata,
    output logic                      rsp_err,
    output logic [WORDS-1:0]          arr_sel,
    output logic                      arr_rw,
    output logic [WIDTH+PAR_BITS-1:0] arr_in,
    input  logic [WIDTH+PAR_BITS-1:0] arr_out
);

    state_e                    state_q, state_d;
    logic                      we_q, we_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [WIDTH-1:0]          wdata_q, wdata_d;
    logic [WIDTH-1:0]          rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      rdy_q;
    logic                      row_en;
    logic                      oob;
    logic                      par_err;
    logic [WIDTH+PAR_BITS-1:0] drive_word;

    bitcell_row_decoder #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_row_dec (
        .en_i   (row_en),
        .addr_i (addr_q),
        .sel_o  (arr_sel),
        .oob_o  (oob)
    );

`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
    assign drive_word = {even_parity(32'(wdata_q)), wdata_q};
    assign par_err    = ^arr_out;
`else
    assign drive_word = wdata_q;
    assign par_err    = 1'b0;
`endif

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // State and latched request/response registers; rdy_q keeps req_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    // Access sequencing: setup, row pulse, hold/capture, then respond; array strobes depend only on state.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        row_en    = 1'b0;
        arr_rw    = 1'b0;
        arr_in    = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = rdy_q;
                if (req_valid && rdy_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                arr_in = drive_word;
                if (oob) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = we_q ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                row_en  = 1'b1;
                arr_rw  = !oob;
                arr_in  = drive_word;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                arr_in  = drive_word;
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_READ: begin
                row_en  = 1'b1;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                row_en  = 1'b1;
                rdata_d = arr_out[WIDTH-1:0];
                err_d   = par_err;
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// tb/tb_bitcell_array_ctrl.sv - randomized self-checking bench with bitcell array and transaction-level reference model
module tb_bitcell_array_ctrl;

    localparam int WORDS = 8;
    localparam int WIDTH = 4;
    localparam int AW    = 4;
    localparam int IW    = $clog2(WORDS);
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int CW = WIDTH + PB;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;
    logic [WORDS-1:0] arr_sel;
    logic             arr_rw;
    logic [CW-1:0]    arr_in;
    logic [CW-1:0]    arr_out;

    logic [CW-1:0]    cells [WORDS] = '{default: '0};
    logic [WIDTH-1:0] ref_mem [WORDS];
    logic             flip_par = 1'b0;
    int               n_assert = 0;
    int               n_fail = 0;
    int               act_cnt = 0;

    bitcell_array_ctrl #(
        .WORDS  (WORDS),
        .WIDTH  (WIDTH),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .arr_sel   (arr_sel),
        .arr_rw    (arr_rw),
        .arr_in    (arr_in),
        .arr_out   (arr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Bitcell array: selected row stores arr_in on a write strobe, drives the shared bus on a read.
    always @(posedge clk) begin
        if (arr_rw) begin
            for (int i = 0; i < WORDS; i++) begin
                if (arr_sel[i]) cells[i] <= arr_in;
            end
        end
    end

    always_comb begin
        arr_out = 'z;
        if (arr_sel != '0 && !arr_rw) begin
            for (int i = 0; i < WORDS; i++) begin
                if (arr_sel[i]) arr_out = cells[i];
            end
        end
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
        if (flip_par) arr_out[WIDTH] = ~arr_out[WIDTH];
`endif
    end

    // Array-side safety rules every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check_val("sel_onehot0", 32'($onehot0(arr_sel)), 32'd1);
            check_val("rw_without_sel", 32'(arr_rw && (arr_sel == '0)), 32'd0);
            if (arr_sel != '0 || arr_rw) act_cnt++;
        end
    end

    task automatic check_rows(input string tag);
        for (int i = 0; i < WORDS; i++) begin
            check_val(tag, 32'(cells[i][WIDTH-1:0]), 32'(ref_mem[i]));
        end
    endtask

    // One request/response exchange, with the expectation taken from the word-level model.
    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [WIDTH-1:0] wd,
                           input int hold, input logic flip);
        logic             oob;
        logic [WIDTH-1:0] exp_d;
        logic             exp_e;
        int               exp_lat;
        int               lat;
        int               acts0;
        oob     = (int'(addr) >= WORDS);
        exp_d   = (we || oob) ? '0 : ref_mem[addr[IW-1:0]];
        exp_e   = oob || (PB == 1 && flip && !we);
        exp_lat = oob ? 2 : 4;
        if (we && !oob) ref_mem[addr[IW-1:0]] = wd;

        @(negedge clk);
        lat = 0;
        while (!req_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_val("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
        flip_par  = flip && !we;
`endif
        acts0 = act_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = WIDTH'($urandom);

        @(negedge clk);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            check_val("req_ready_busy", 32'(req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check_val("rsp_latency", 32'(lat), 32'(exp_lat));
        check_val("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
        check_val("rsp_err", 32'(rsp_err), 32'(exp_e));
        if (oob) check_val("oob_array_activity", 32'(act_cnt - acts0), 32'd0);

        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_val("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check_val("bp_rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
            check_val("bp_rsp_err", 32'(rsp_err), 32'(exp_e));
            check_val("bp_req_ready", 32'(req_ready), 32'd0);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
        flip_par  = 1'b0;
`endif
        @(negedge clk);
        check_val("rsp_done_valid", 32'(rsp_valid), 32'd0);
        check_val("rsp_done_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic              we;
        logic [AW-1:0]     addr;
        logic              found;
        logic [WIDTH-1:0]  wd;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // Reset state
        #1;
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_arr_sel", 32'(arr_sel), 32'd0);
        check_val("rst_arr_rw", 32'(arr_rw), 32'd0);
        check_val("rst_arr_in", 32'(arr_in), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rel_req_ready_pre_edge", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check_val("rel_req_ready_post_edge", 32'(req_ready), 32'd1);

        // Directed write/read pairs
        run_txn(1'b1, 4'd3, 4'b1010, 0, 1'b0);
        run_txn(1'b0, 4'd3, 4'h0, 0, 1'b0);
        run_txn(1'b1, 4'd0, 4'hF, 0, 1'b0);
        run_txn(1'b1, 4'd7, 4'h0, 0, 1'b0);
        run_txn(1'b0, 4'd0, 4'h0, 0, 1'b0);
        run_txn(1'b0, 4'd7, 4'h0, 0, 1'b0);
        check_rows("rows_after_directed");

        // Backpressure on a read
        run_txn(1'b0, 4'd3, 4'h0, 10, 1'b0);

        // Out-of-range addresses
        run_txn(1'b0, 4'd9, 4'h0, 0, 1'b0);
        run_txn(1'b1, 4'd9, 4'h5, 1, 1'b0);
        run_txn(1'b1, 4'd8, 4'hA, 0, 1'b0);
        run_txn(1'b0, 4'd15, 4'h0, 0, 1'b0);
        check_rows("rows_after_oob");

`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
        // Corrupted parity column on read
        run_txn(1'b1, 4'd2, 4'h6, 0, 1'b0);
        run_txn(1'b0, 4'd2, 4'h0, 0, 1'b1);
        run_txn(1'b0, 4'd2, 4'h0, 0, 1'b0);
`endif

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            we   = 1'($urandom);
            addr = AW'($urandom_range(0, 11));
            run_txn(we, addr, WIDTH'($urandom), int'($urandom_range(0, 3)),
                    (PB == 1) && ($urandom_range(0, 3) == 0));
        end
        check_rows("rows_after_random");

        // Reset asserted during the write pulse
        @(negedge clk);
        wd = ~ref_mem[5];
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd5;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (arr_rw) begin
                found = 1'b1;
                break;
            end
        end
        check_val("write_pulse_seen", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("abort_arr_sel", 32'(arr_sel), 32'd0);
        check_val("abort_arr_rw", 32'(arr_rw), 32'd0);
        check_val("abort_arr_in", 32'(arr_in), 32'd0);
        check_val("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("abort_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("abort_rel_ready_pre", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check_val("abort_rel_ready_post", 32'(req_ready), 32'd1);
        check_val("abort_rel_rw", 32'(arr_rw), 32'd0);
        check_rows("rows_after_abort");
        run_txn(1'b0, 4'd5, 4'h0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
